// File: rtl/forth_pkg.sv
// Shared definitions for the Forth data-stack block.
// Op codes, error classes and per-op depth rules.
package forth_pkg;

  typedef enum logic [2:0] {
    OP_NOP  = 3'd0,
    OP_PUSH = 3'd1,
    OP_DROP = 3'd2,
    OP_DUP  = 3'd3,
    OP_SWAP = 3'd4,
    OP_OVER = 3'd5,
    OP_REPL = 3'd6,
    OP_BIN  = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    ERR_NONE = 2'd0,
    ERR_OVF  = 2'd1,
    ERR_UNF  = 2'd2
  } stack_err_e;

  function automatic logic [1:0] min_depth(op_e op);
    logic [1:0] n;
    n = 2'd0;
    unique case (op)
      OP_DROP, OP_DUP, OP_REPL: n = 2'd1;
      OP_SWAP, OP_OVER, OP_BIN: n = 2'd2;
      default:                  n = 2'd0;
    endcase
    return n;
  endfunction

  function automatic logic grows(op_e op);
    return (op == OP_PUSH) || (op == OP_DUP) || (op == OP_OVER);
  endfunction

endpackage

// File: rtl/forth_stack_ram.sv
// Spill store for cells below nos.
// One write port, one combinational read port.
module forth_stack_ram
  import forth_pkg::*;
#(
  parameter int WIDTH   = 3,
  parameter int ENTRIES = 6,
  parameter int AW      = 3
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [ENTRIES];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/forth_stack.sv
// Forth data stack: tos/nos in registers, deeper cells spilled.
// Single-cycle ops with overflow/underflow rejection.
module forth_stack
  import forth_pkg::*;
#(
  parameter int WIDTH = 3,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [2:0]                 op,
  input  logic [WIDTH-1:0]           data_in,
  input  logic                       clr_err,
  output logic [WIDTH-1:0]           tos,
  output logic [WIDTH-1:0]           nos,
  output logic [$clog2(DEPTH+1)-1:0] depth,
  output logic                       empty,
  output logic                       full,
  output logic                       ovf,
  output logic                       unf,
  output logic                       err_pulse
);

  localparam int DW = $clog2(DEPTH+1);
  localparam int NE = DEPTH - 2;
  localparam int AW = (NE > 1) ? $clog2(NE) : 1;

  logic [WIDTH-1:0] tos_q, tos_d;
  logic [WIDTH-1:0] nos_q, nos_d;
  logic [DW-1:0]    depth_q, depth_d;
  logic             ovf_q, unf_q, err_q;
  logic             we;
  logic [AW-1:0]    waddr, raddr;
  logic [WIDTH-1:0] rd_data, third;
  stack_err_e       err;
  op_e              opc;
  logic [1:0]       need;

  assign opc  = op_e'(op);
  assign need = min_depth(opc);

  // Third cell lives at depth-3; a growing op spills nos to depth-2.
  assign raddr = AW'(depth_q - DW'(3));
  assign waddr = AW'(depth_q - DW'(2));
  assign third = (depth_q >= DW'(3)) ? rd_data : '0;

  forth_stack_ram #(
    .WIDTH   (WIDTH),
    .ENTRIES (NE),
    .AW      (AW)
  ) u_ram (
    .clk   (clk),
    .we    (we),
    .waddr (waddr),
    .wdata (nos_q),
    .raddr (raddr),
    .rdata (rd_data)
  );

  always_comb begin
    tos_d   = tos_q;
    nos_d   = nos_q;
    depth_d = depth_q;
    we      = 1'b0;
    err     = ERR_NONE;
    if (grows(opc) && full) begin
      err = ERR_OVF;
    end else if (depth_q < DW'(need)) begin
      err = ERR_UNF;
    end else begin
      unique case (opc)
        OP_NOP: begin
        end
        OP_PUSH: begin
          tos_d   = data_in;
          nos_d   = tos_q;
          we      = depth_q >= DW'(2);
          depth_d = depth_q + DW'(1);
        end
        OP_DROP: begin
          tos_d   = nos_q;
          nos_d   = third;
          depth_d = depth_q - DW'(1);
        end
        OP_DUP: begin
          nos_d   = tos_q;
          we      = depth_q >= DW'(2);
          depth_d = depth_q + DW'(1);
        end
        OP_SWAP: begin
          tos_d = nos_q;
          nos_d = tos_q;
        end
        OP_OVER: begin
          tos_d   = nos_q;
          nos_d   = tos_q;
          we      = 1'b1;
          depth_d = depth_q + DW'(1);
        end
        OP_REPL: begin
          tos_d = data_in;
        end
        OP_BIN: begin
          tos_d   = data_in;
          nos_d   = third;
          depth_d = depth_q - DW'(1);
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tos_q   <= '0;
      nos_q   <= '0;
      depth_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      tos_q   <= tos_d;
      nos_q   <= nos_d;
      depth_q <= depth_d;
      ovf_q   <= (ovf_q & ~clr_err) | (err == ERR_OVF);
      unf_q   <= (unf_q & ~clr_err) | (err == ERR_UNF);
      err_q   <= err != ERR_NONE;
    end
  end

  assign empty     = depth_q == '0;
  assign full      = depth_q == DW'(DEPTH);
  assign depth     = depth_q;
  assign tos       = empty ? '0 : tos_q;
  assign nos       = (depth_q < DW'(2)) ? '0 : nos_q;
  assign ovf       = ovf_q;
  assign unf       = unf_q;
  assign err_pulse = err_q;

endmodule
